// File: rtl/imload_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imload_pkg;

  localparam int unsigned IM_DEPTH          = 2048;
  localparam int unsigned IM_AW             = 11;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h55;

  typedef enum logic [2:0] {
    SYNC,
    CNT_LO,
    CNT_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } imload_state_e;

endpackage

// File: rtl/imload_word_asm.sv
// Little-endian byte-to-word assembler with running XOR of frame bytes.
// Optional checksum accumulation is built only with IMLOAD_CHECKSUM_EN.
module imload_word_asm
  import imload_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
`ifdef IMLOAD_CHECKSUM_EN
  input  logic        csum_en_i,
  output logic [7:0]  csum_o,
`endif
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (shift_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  // High while the next shifted byte completes the current word.
  assign word_ready_o = (idx_q == 2'd3);
  assign word_o       = word_q;

`ifdef IMLOAD_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear_i) begin
      csum_d = '0;
    end else if (csum_en_i) begin
      csum_d = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
`endif

endmodule

// File: rtl/im_boot_loader.sv
// Serial boot loader: holds the CPU, writes a framed image into IM, then hands IM back.
// Define IMLOAD_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module im_boot_loader
  import imload_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        charReady,
  input  logic [7:0]  RXchar,
  output logic        readRX,
  input  logic        cpuStoreI,
  input  logic [10:0] cpuAddr,
  input  logic [31:0] cpuData,
  output logic        imWe,
  output logic [10:0] imAddr,
  output logic [31:0] imDin,
  output logic        cpuHold,
  output logic        loadDone,
  output logic        loadError
);

  localparam int unsigned     TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     DEPTH16      = 16'(IM_DEPTH);
  localparam logic [IM_AW:0]  ONE_WORD     = {{IM_AW{1'b0}}, 1'b1};

  imload_state_e    state_q, state_d;
  logic [IM_AW-1:0] addr_q, addr_d;
  logic [IM_AW:0]   remaining_q, remaining_d;
  logic [7:0]       count_lo_q, count_lo_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             armed_q, armed_d;
  logic             load_error_q, load_error_d;
  logic             gap_q, gap_d;

  logic             receiving;
  logic             consume;
  logic             frame_start;
  logic             shift;
  logic             word_ready;
  logic [31:0]      word;
  logic [15:0]      count;

  always_comb begin
    case (state_q)
      SYNC, CNT_LO, CNT_HI, DATA: receiving = 1'b1;
`ifdef IMLOAD_CHECKSUM_EN
      CSUM:                       receiving = 1'b1;
`endif
      default:                    receiving = 1'b0;
    endcase
  end

  // gap_q enforces the idle cycle while rs232 still shows the stale byte.
  assign consume     = receiving && charReady && !gap_q && !Reset;
  assign frame_start = consume && (state_q == SYNC) && (RXchar == SYNC_BYTE);
  assign shift       = consume && (state_q == DATA);
  assign count       = {RXchar, count_lo_q};

`ifdef IMLOAD_CHECKSUM_EN
  logic       csum_en;
  logic [7:0] csum;

  assign csum_en = consume && (state_q inside {CNT_LO, CNT_HI, DATA});
`endif

  imload_word_asm u_word_asm (
    .Clock        (Clock),
    .Reset        (Reset),
    .clear_i      (frame_start),
    .shift_i      (shift),
    .byte_i       (RXchar),
`ifdef IMLOAD_CHECKSUM_EN
    .csum_en_i    (csum_en),
    .csum_o       (csum),
`endif
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    count_lo_d   = count_lo_q;
    timer_d      = timer_q;
    armed_d      = armed_q;
    load_error_d = load_error_q;
    gap_d        = consume;
    case (state_q)
      SYNC: begin
        if (frame_start) begin
          state_d = CNT_LO;
          addr_d  = '0;
        end else if (armed_q) begin
          if (timer_q == TIMEOUT_LAST) begin
            state_d = DONE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      CNT_LO: begin
        if (consume) begin
          count_lo_d = RXchar;
          state_d    = CNT_HI;
        end
      end
      CNT_HI: begin
        if (consume) begin
          if (count > DEPTH16) begin
            state_d = ERROR;
          end else if (count == '0) begin
            state_d = CSUM;
          end else begin
            remaining_d = count[IM_AW:0];
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        if (shift && word_ready) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d      = addr_q + IM_AW'(1);
        remaining_d = remaining_q - ONE_WORD;
        state_d     = (remaining_q == ONE_WORD) ? CSUM : DATA;
      end
      CSUM: begin
`ifdef IMLOAD_CHECKSUM_EN
        if (consume) begin
          if (RXchar == csum) begin
            state_d      = DONE;
            load_error_d = 1'b0;
          end else begin
            state_d = ERROR;
          end
        end
`else
        state_d      = DONE;
        load_error_d = 1'b0;
`endif
      end
      ERROR: begin
        load_error_d = 1'b1;
        armed_d      = 1'b0;
        state_d      = SYNC;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= SYNC;
      addr_q       <= '0;
      remaining_q  <= '0;
      count_lo_q   <= '0;
      timer_q      <= '0;
      armed_q      <= 1'b1;
      load_error_q <= 1'b0;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      count_lo_q   <= count_lo_d;
      timer_q      <= timer_d;
      armed_q      <= armed_d;
      load_error_q <= load_error_d;
      gap_q        <= gap_d;
    end
  end

  always_comb begin
    readRX    = consume;
    cpuHold   = (state_q != DONE);
    loadDone  = (state_q == DONE);
    loadError = load_error_q;
    if (state_q == DONE) begin
      imWe   = cpuStoreI;
      imAddr = cpuAddr;
      imDin  = cpuData;
    end else begin
      imWe   = (state_q == WRITE);
      imAddr = addr_q;
      imDin  = word;
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Bench for im_boot_loader: rs232 byte driver, observed IM image, frame-level reference expectations.
module tb_im_boot_loader;

`ifdef IMLOAD_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        charReady;
  logic [7:0]  RXchar;
  logic        readRX;
  logic        cpuStoreI;
  logic [10:0] cpuAddr;
  logic [31:0] cpuData;
  logic        imWe;
  logic [10:0] imAddr;
  logic [31:0] imDin;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;

  im_boot_loader #(.TIMEOUT_CYCLES(100)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .charReady (charReady),
    .RXchar    (RXchar),
    .readRX    (readRX),
    .cpuStoreI (cpuStoreI),
    .cpuAddr   (cpuAddr),
    .cpuData   (cpuData),
    .imWe      (imWe),
    .imAddr    (imAddr),
    .imDin     (imDin),
    .cpuHold   (cpuHold),
    .loadDone  (loadDone),
    .loadError (loadError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int unsigned count;
    int unsigned garbage;
    bit          bad_csum;
    bit          do_rst;
    bit          exp_done;
    bit          exp_err;
    int unsigned exp_wr;
  } vec_t;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned wr_count    = 0;
  int unsigned b2b         = 0;
  logic        prev_rd     = 1'b0;
  logic [31:0] obs_mem [0:2047];
  logic [31:0] frame_w [$];
  vec_t        tbl [$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // IM model and readRX spacing monitor, sampled late in the low clock phase.
  initial begin
    forever begin
      @(negedge Clock);
      #2;
      if (readRX && prev_rd) b2b++;
      prev_rd = readRX;
      if (imWe === 1'b1 && cpuHold === 1'b1) begin
        obs_mem[imAddr] = imDin;
        wr_count++;
      end
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset     = 1'b1;
    charReady = 1'b0;
    cpuStoreI = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  // rs232 behaviour: byte stays visible through the cycle after readRX, then drops.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    @(negedge Clock);
    charReady = 1'b1;
    RXchar    = b;
    #1;
    while (!readRX && n < 64) begin
      @(negedge Clock);
      #1;
      n++;
    end
    if (!readRX) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_wait: byte %h never consumed after %0d cycles", b, n);
      charReady = 1'b0;
      return;
    end
    @(negedge Clock);
    @(negedge Clock);
    charReady = 1'b0;
  endtask

  task automatic run_frame(input int unsigned count, input int unsigned garbage, input bit bad_csum,
                           input bit do_rst, input bit exp_done, input bit exp_err,
                           input int unsigned exp_wr, input string tag);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] cnt16;
    int unsigned wr0;
    int unsigned bad;
    if (do_rst) do_reset();
    wr0   = wr_count;
    cnt16 = 16'(count);
    if (count <= 2048) begin
      while (frame_w.size() < count) frame_w.push_back($urandom);
    end
    for (int g = 0; g < int'(garbage); g++) send_byte((g % 2 == 0) ? 8'hAA : 8'h00);
    send_byte(8'h55);
    cs = cnt16[7:0] ^ cnt16[15:8];
    send_byte(cnt16[7:0]);
    send_byte(cnt16[15:8]);
    if (count <= 2048) begin
      for (int i = 0; i < int'(count); i++) begin
        for (int k = 0; k < 4; k++) begin
          b  = frame_w[i][8*k +: 8];
          cs = cs ^ b;
          send_byte(b);
        end
      end
      if (CS) send_byte(bad_csum ? ~cs : cs);
    end
    repeat (6) @(negedge Clock);
    #1;
    check($sformatf("%s_loadDone", tag), 32'(loadDone), 32'(exp_done));
    check($sformatf("%s_loadError", tag), 32'(loadError), 32'(exp_err));
    check($sformatf("%s_cpuHold", tag), 32'(cpuHold), 32'(!exp_done));
    check($sformatf("%s_writes", tag), wr_count - wr0, exp_wr);
    if (count <= 2048) begin
      bad = 0;
      for (int i = 0; i < int'(count); i++) if (obs_mem[i] !== frame_w[i]) bad++;
      check($sformatf("%s_im_words_bad", tag), bad, 0);
    end
    frame_w.delete();
  endtask

  initial begin
    logic [31:0] wm;
    int unsigned wr0;
    int unsigned n;
    int unsigned rc;
    int unsigned rg;
    bit          rb;

    Reset     = 1'b1;
    charReady = 1'b0;
    RXchar    = 8'h00;
    cpuStoreI = 1'b0;
    cpuAddr   = '0;
    cpuData   = '0;

    do_reset();
    #1;
    check("rst_cpuHold", 32'(cpuHold), 1);
    check("rst_loadDone", 32'(loadDone), 0);
    check("rst_loadError", 32'(loadError), 0);
    check("rst_readRX", 32'(readRX), 0);
    check("rst_imWe", 32'(imWe), 0);
    check("rst_imAddr", 32'(imAddr), 0);
    check("rst_imDin", imDin, 0);
    cpuStoreI = 1'b1;
    cpuAddr   = 11'h7FF;
    #1;
    check("hold_ignores_cpuStoreI", 32'(imWe), 0);
    cpuStoreI = 1'b0;

    frame_w.push_back(32'h12345678);
    frame_w.push_back(32'hDEADBEEF);
    run_frame(2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2, "plan_frame");
    check("plan_im0", obs_mem[0], 32'h12345678);
    check("plan_im1", obs_mem[1], 32'hDEADBEEF);

    @(negedge Clock);
    cpuStoreI = 1'b1;
    cpuAddr   = 11'h123;
    cpuData   = 32'hCAFEF00D;
    #1;
    check("pass_imWe", 32'(imWe), 1);
    check("pass_imAddr", 32'(imAddr), 32'h123);
    check("pass_imDin", imDin, 32'hCAFEF00D);
    cpuStoreI = 1'b0;
    #1;
    check("pass_imWe_low", 32'(imWe), 0);

    do_reset();
    #1;
    check("done_reset_cpuHold", 32'(cpuHold), 1);
    check("done_reset_loadDone", 32'(loadDone), 0);

    do_reset();
    wr0 = wr_count;
    repeat (99) @(negedge Clock);
    #1;
    check("timeout_cycle99_loadDone", 32'(loadDone), 0);
    @(negedge Clock);
    #1;
    check("timeout_cycle100_loadDone", 32'(loadDone), 1);
    check("timeout_cpuHold", 32'(cpuHold), 0);
    check("timeout_no_writes", wr_count - wr0, 0);

    tbl.push_back('{1,    0, 1'b0, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{3,    0, 1'b0, 1'b1, 1'b1, 1'b0, 3});
    tbl.push_back('{0,    0, 1'b0, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{2,    2, 1'b0, 1'b1, 1'b1, 1'b0, 2});
    tbl.push_back('{4,    0, 1'b1, 1'b1, !CS,  CS,   4});
    tbl.push_back('{2,    0, 1'b0, !CS,  1'b1, 1'b0, 2});
    tbl.push_back('{2049, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0});
    tbl.push_back('{1,    1, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{2048, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2048});
    for (int i = 0; i < tbl.size(); i++) begin
      run_frame(tbl[i].count, tbl[i].garbage, tbl[i].bad_csum, tbl[i].do_rst,
                tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_wr, $sformatf("tbl%0d", i));
    end

    // Error first so the mid-frame reset also has a sticky loadError to clear.
    run_frame(2049, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0, "mid_pre_err");
    wm = 32'h0F1E2D3C;
    send_byte(8'h55);
    send_byte(8'h03);
    send_byte(8'h00);
    wr0 = wr_count;
    for (int k = 0; k < 4; k++) send_byte(wm[8*k +: 8]);
    n = 0;
    while (wr_count == wr0 && n < 20) begin
      @(negedge Clock);
      #3;
      n++;
    end
    check("mid_word0_written", wr_count - wr0, 1);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    check("mid_rst_cpuHold", 32'(cpuHold), 1);
    check("mid_rst_loadDone", 32'(loadDone), 0);
    check("mid_rst_loadError", 32'(loadError), 0);
    check("mid_rst_imWe", 32'(imWe), 0);
    Reset = 1'b0;
    check("mid_im0_kept", obs_mem[0], wm);
    run_frame(1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, "after_mid_reset");

    for (int i = 0; i < 8; i++) begin
      rc = $urandom_range(1, 5);
      rg = $urandom_range(0, 2);
      rb = CS ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(rc, rg, rb, 1'b1, !rb, rb, rc, $sformatf("rnd%0d", i));
    end

    check("readRX_back_to_back", b2b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
